// File: rtl/vblank_update_scheduler.sv
// ============================================================================
// Module   : vblank_update_scheduler
// Purpose  : Sequences per-frame object updates during vertical blanking.
//            Detects vblank start from the VGA pixel coordinates, then issues
//            one-cycle start pulses to each enabled client in turn, waiting
//            for that client's done (or a timeout) before moving on. Passes
//            still running when active video resumes are aborted and flagged.
// Options  : SCHED_ROUND_ROBIN_EN - when defined, the first client visited
//            rotates by one after every pass that starts.
// Ports    : clk25        in  pixel clock
//            rst          in  synchronous active-high reset
//            x, y         in  current VGA column / row
//            enable_mask  in  client enables, latched at pass start
//            done         in  client completion pulses
//            clear_flags  in  clears timeout_flag and overrun
//            start        out one-hot, one-cycle client start pulse
//            busy         out high while a pass is in progress
//            frame_tick   out one-cycle pulse per frame
//            frame_count  out frames seen since reset (16-bit wrap)
//            timeout_flag out sticky per-client timeout
//            overrun      out sticky, pass aborted by active video
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vblank_update_scheduler #(
    parameter int N_CLIENTS = 4,
    parameter int V_ACTIVE  = 480,
    parameter int TIMEOUT   = 1024,
    parameter int FRAME_DIV = 1
) (
    input  logic                 clk25,
    input  logic                 rst,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic [N_CLIENTS-1:0] enable_mask,
    input  logic [N_CLIENTS-1:0] done,
    input  logic                 clear_flags,
    output logic [N_CLIENTS-1:0] start,
    output logic                 busy,
    output logic                 frame_tick,
    output logic [15:0]          frame_count,
    output logic [N_CLIENTS-1:0] timeout_flag,
    output logic                 overrun
);

    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int CW = $clog2(N_CLIENTS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;       // slots visited this pass
    logic [15:0]          timer_q, timer_d;
    logic [7:0]           div_q, div_d;
    logic [N_CLIENTS-1:0] mask_q, mask_d;
    logic                 vb_q, vb_d;
    logic                 vb_prev_q, vb_prev_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [15:0]          frame_count_q, frame_count_d;
    logic [N_CLIENTS-1:0] timeout_flag_q, timeout_flag_d;
    logic                 overrun_q, overrun_d;
    logic [IW-1:0]        first_idx;
    logic                 vb_event;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(N_CLIENTS - 1)) ? '0 : i + IW'(1);
    endfunction

`ifdef SCHED_ROUND_ROBIN_EN
    logic [IW-1:0] rot_q, rot_d;
    assign first_idx = rot_q;
`else
    assign first_idx = '0;
`endif

    // Rising edge of the registered vblank condition: one event per frame
    // even if x stalls at 0 on the first blanking line.
    assign vb_event = vb_q & ~vb_prev_q;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        timer_d        = timer_q;
        div_d          = div_q;
        mask_d         = mask_q;
        vb_d           = (y == 10'(V_ACTIVE)) && (x == 10'd0);
        vb_prev_d      = vb_q;
        frame_tick_d   = vb_event;
        frame_count_d  = frame_count_q + {15'd0, vb_event};
        // Clear first so that a set in the same cycle takes precedence.
        timeout_flag_d = clear_flags ? '0 : timeout_flag_q;
        overrun_d      = clear_flags ? 1'b0 : overrun_q;
        start          = '0;
`ifdef SCHED_ROUND_ROBIN_EN
        rot_d          = rot_q;
`endif

        if (vb_event) begin
            div_d = (div_q == 8'(FRAME_DIV - 1)) ? 8'd0 : div_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (vb_event && (div_q == 8'd0)) begin
                    mask_d  = enable_mask;
                    idx_d   = first_idx;
                    cnt_d   = '0;
                    state_d = S_SCAN;
`ifdef SCHED_ROUND_ROBIN_EN
                    rot_d   = next_idx(rot_q);
`endif
                end
            end
            S_SCAN: begin
                if (cnt_q == CW'(N_CLIENTS)) begin
                    state_d = S_IDLE;
                end else if (mask_q[idx_q]) begin
                    state_d = S_ISSUE;
                end else begin
                    idx_d = next_idx(idx_q);
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ISSUE: begin
                start[idx_q] = 1'b1;
                timer_d      = '0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (done[idx_q]) begin
                    idx_d   = next_idx(idx_q);
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_SCAN;
                end else if (timer_q == 16'(TIMEOUT - 1)) begin
                    timeout_flag_d[idx_q] = 1'b1;
                    idx_d   = next_idx(idx_q);
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_SCAN;
                end else if ((y == 10'd0) && (x == 10'd0)) begin
                    // Active video is back: abandon the rest of this pass.
                    overrun_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            timer_q        <= '0;
            div_q          <= '0;
            mask_q         <= '0;
            vb_q           <= 1'b0;
            vb_prev_q      <= 1'b0;
            frame_tick_q   <= 1'b0;
            frame_count_q  <= '0;
            timeout_flag_q <= '0;
            overrun_q      <= 1'b0;
`ifdef SCHED_ROUND_ROBIN_EN
            rot_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            timer_q        <= timer_d;
            div_q          <= div_d;
            mask_q         <= mask_d;
            vb_q           <= vb_d;
            vb_prev_q      <= vb_prev_d;
            frame_tick_q   <= frame_tick_d;
            frame_count_q  <= frame_count_d;
            timeout_flag_q <= timeout_flag_d;
            overrun_q      <= overrun_d;
`ifdef SCHED_ROUND_ROBIN_EN
            rot_q          <= rot_d;
`endif
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign frame_tick   = frame_tick_q;
    assign frame_count  = frame_count_q;
    assign timeout_flag = timeout_flag_q;
    assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_vblank_update_scheduler.sv
// ============================================================================
// Module   : tb_vblank_update_scheduler
// Purpose  : Directed self-checking bench for vblank_update_scheduler. A main
//            instance (TIMEOUT=16) runs the sequencing scenarios; a second
//            instance (FRAME_DIV=3, empty mask) checks pass gating.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vblank_update_scheduler;

    localparam int N = 4;

    logic         clk25 = 1'b0;
    logic         rst;
    logic [9:0]   x, y;
    logic [N-1:0] mask, done, clear;
    logic [N-1:0] start, tflag;
    logic         busy, ftick, ovr;
    logic [15:0]  fcount;

    logic [N-1:0] d_mask, d_done, d_start, d_tflag;
    logic         d_busy, d_ftick, d_ovr;
    logic [15:0]  d_fcount;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ack [N];
    int due [N];

    always #5 clk25 = ~clk25;
    always @(posedge clk25) cyc <= cyc + 1;

    vblank_update_scheduler #(.N_CLIENTS(N), .V_ACTIVE(480), .TIMEOUT(16), .FRAME_DIV(1)) u_dut (
        .clk25(clk25), .rst(rst), .x(x), .y(y), .enable_mask(mask), .done(done),
        .clear_flags(clear[0]), .start(start), .busy(busy), .frame_tick(ftick),
        .frame_count(fcount), .timeout_flag(tflag), .overrun(ovr)
    );

    vblank_update_scheduler #(.N_CLIENTS(N), .V_ACTIVE(480), .TIMEOUT(16), .FRAME_DIV(3)) u_div (
        .clk25(clk25), .rst(rst), .x(x), .y(y), .enable_mask(d_mask), .done(d_done),
        .clear_flags(clear[0]), .start(d_start), .busy(d_busy), .frame_tick(d_ftick),
        .frame_count(d_fcount), .timeout_flag(d_tflag), .overrun(d_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present the vblank coordinate for one cycle; returns in the cycle
    // where frame_tick should be high.
    task automatic frame();
        y = 10'd480; x = 10'd0;
        tick();
        y = 10'd100; x = 10'd1;
        tick();
    endtask

    task automatic wait_start(input int bound, output logic [N-1:0] s, output int c);
        s = '0;
        c = -1;
        for (int k = 0; k < bound && s == '0; k++) begin
            tick();
            if (start != '0) begin
                s = start;
                c = cyc;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output logic [N-1:0] seen, output int c);
        seen = '0;
        c    = -1;
        for (int k = 0; k < bound && c < 0; k++) begin
            tick();
            seen = seen | start;
            if (!busy) c = cyc;
        end
    endtask

    // Client model: done[i] pulses ack[i] cycles after start[i] (0 = never).
    initial begin
        done = '0;
        for (int i = 0; i < N; i++) due[i] = -1;
        forever begin
            @(posedge clk25);
            #1;
            done = '0;
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    due[i] = -1;
                end else begin
                    if (start[i] && ack[i] > 0) due[i] = cyc + ack[i];
                    if (due[i] == cyc) begin
                        done[i] = 1'b1;
                        due[i]  = -1;
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0] s, seen;
        int c, f;

        rst = 1'b1; x = 10'd5; y = 10'd100; mask = '0; clear = '0;
        d_mask = '0; d_done = '0;
        for (int i = 0; i < N; i++) ack[i] = 3;
        tick_n(3);

        // Reset state
        chk("rst_start", 32'(start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ftick", 32'(ftick), 0);
        chk("rst_fcount", 32'(fcount), 0);
        chk("rst_tflag", 32'(tflag), 0);
        chk("rst_ovr", 32'(ovr), 0);
        rst = 1'b0;
        tick_n(2);

        // 1: all clients enabled, ack after 3 cycles
        mask = 4'b1111;
        frame();
        f = cyc;
        chk("t1_ftick", 32'(ftick), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_fcount", 32'(fcount), 1);
        for (int k = 0; k < N; k++) begin
            wait_start(20, s, c);
            chk("t1_start_idx", 32'(s), 32'(1 << k));
            chk("t1_start_cyc", 32'(c - f), 32'(1 + 5 * k));
            if (k == 0) chk("t1_ftick_one", 32'(ftick), 0);
        end
        wait_idle(20, seen, c);
        chk("t1_idle_cyc", 32'(c - f), 21);

        // 2: sparse mask, disabled clients skipped
        mask = 4'b0101;
        tick_n(3);
        frame();
        f = cyc;
        chk("t2_fcount", 32'(fcount), 2);
        wait_start(20, s, c);
        chk("t2_start0", 32'(s), 32'b0001);
        wait_start(20, s, c);
        chk("t2_start2", 32'(s), 32'b0100);
        chk("t2_start2_cyc", 32'(c - f), 7);
        wait_idle(20, seen, c);
        chk("t2_no_more", 32'(seen), 0);
        chk("t2_idle_cyc", 32'(c - f), 13);

        // 3: client 1 never acks -> timeout flag, then clear, then set+clear
        mask = 4'b1111;
        ack[1] = 0;
        tick_n(3);
        frame();
        f = cyc;
        wait_start(20, s, c);
        wait_start(20, s, c);
        chk("t3_start1_cyc", 32'(c - f), 6);
        wait_start(40, s, c);
        chk("t3_start2", 32'(s), 32'b0100);
        chk("t3_start2_cyc", 32'(c - f), 24);
        chk("t3_tflag", 32'(tflag), 32'b0010);
        wait_idle(40, seen, c);
        chk("t3_start3", 32'(seen), 32'b1000);
        clear = 4'b0001;
        tick();
        clear = '0;
        chk("t3_cleared", 32'(tflag), 0);
        tick_n(3);
        frame();
        tick_n(22);
        clear = 4'b0001;
        tick();
        clear = '0;
        chk("t3_set_wins", 32'(tflag), 32'b0010);
        wait_idle(60, seen, c);
        chk("t3_sticky", 32'(tflag), 32'b0010);

        // 4: client 2 holds off past the wrap to line 0 -> overrun
        ack[1] = 3;
        ack[2] = 0;
        tick_n(3);
        frame();
        f = cyc;
        for (int k = 0; k < 3; k++) wait_start(20, s, c);
        chk("t4_start2", 32'(s), 32'b0100);
        tick_n(2);
        y = 10'd0; x = 10'd0;
        tick();
        y = 10'd100; x = 10'd5;
        chk("t4_ovr", 32'(ovr), 1);
        chk("t4_busy", 32'(busy), 0);
        seen = '0;
        for (int k = 0; k < 30; k++) begin
            tick();
            seen = seen | start;
        end
        chk("t4_no_start3", 32'(seen), 0);
        ack[2] = 3;
        frame();
        f = cyc;
        for (int k = 0; k < N; k++) begin
            wait_start(20, s, c);
            chk("t4_next_idx", 32'(s), 32'(1 << k));
            chk("t4_next_cyc", 32'(c - f), 32'(1 + 5 * k));
        end
        wait_idle(20, seen, c);
        chk("t4_ovr_sticky", 32'(ovr), 1);
        clear = 4'b0001;
        tick();
        clear = '0;
        chk("t4_ovr_clr", 32'(ovr), 0);
        chk("t4_tflag_clr", 32'(tflag), 0);

        // 5: FRAME_DIV=3 instance with an empty mask over six frames
        rst = 1'b1;
        tick_n(2);
        rst = 1'b0;
        mask = '0;
        tick_n(2);
        for (int k = 1; k <= 6; k++) begin
            frame();
            chk("t5_ftick", 32'(d_ftick), 1);
            chk("t5_pass", 32'(d_busy), 32'((k == 1) || (k == 4)));
            if (k == 1) begin
                tick_n(4);
                chk("t5_busy_len", 32'(d_busy), 1);
                tick();
                chk("t5_busy_end", 32'(d_busy), 0);
                tick_n(3);
            end else begin
                tick_n(8);
            end
            chk("t5_no_start", 32'(d_start), 0);
        end
        chk("t5_fcount", 32'(d_fcount), 6);

        // 6: first client of each pass (rotates only with round robin)
        rst = 1'b1;
        tick_n(2);
        rst = 1'b0;
        mask = 4'b1111;
        tick_n(2);
        for (int k = 0; k < 3; k++) begin
            frame();
            wait_start(20, s, c);
`ifdef SCHED_ROUND_ROBIN_EN
            chk("t6_first", 32'(s), 32'(1 << k));
`else
            chk("t6_first", 32'(s), 32'b0001);
`endif
            wait_idle(40, seen, c);
            tick_n(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vblank_update_scheduler.md
Name: vblank_update_scheduler

Overview:
- Sequences per-frame object updates (star field, player, enemies, bullets) during vertical blanking so that object position registers never change mid-scanline.
- Watches the VGA pixel coordinates and detects vblank start.
- Issues one-cycle start pulses to each enabled client in turn and waits for each client's done or a timeout.
- Flags clients that time out, and flags passes that are still running when active video resumes. It replaces free-running per-controller frame counters.

Parameters:
- N_CLIENTS, 4, number of update clients (1..8).
- V_ACTIVE, 480, first non-visible line; vblank begins when y==V_ACTIVE and x==0.
- TIMEOUT, 1024, max cycles to wait for done after a start pulse (2..65535).
- FRAME_DIV, 1, run an update pass every FRAME_DIV frames (1..255).

Ports:
- clk25 in 1: pixel clock, 25 MHz.
- rst in 1: synchronous, active-high reset.
- x in 10: current VGA column.
- y in 10: current VGA row.
- enable_mask in N_CLIENTS: client enables, latched at pass start.
- done in N_CLIENTS: client completion pulses.
- clear_flags in 1: clears the sticky flags.
- start out N_CLIENTS: one-hot, one-cycle start pulse.
- busy out 1: high while a pass is in progress.
- frame_tick out 1: one-cycle pulse per frame.
- frame_count out 16: frames seen since reset.
- timeout_flag out N_CLIENTS: sticky per-client timeout.
- overrun out 1: sticky, pass aborted by active video.

Behaviour:
- Reset (synchronous, rst high at clk25 edge): all outputs 0; state IDLE; idx=0; timer=0; div counter=0; latched mask=0. Reset mid-pass aborts immediately with no further start pulses.
- Event detection: vb = (y==V_ACTIVE && x==0), registered. The event is the cycle where vb is 1 and the previous vb was 0, so it fires once per frame even if x stalls.
- On an event at edge T, frame_tick=1 during cycle T+1 and frame_count increments (16-bit wrap, 0xFFFF->0).
- Pass gating: the div counter counts 0..FRAME_DIV-1 and wraps. A pass starts only on events where the counter is 0. The first event after reset starts a pass. When a pass starts: latch enable_mask, set idx to the start index, state SCAN, busy=1 from T+1.
- SCAN: if all N_CLIENTS slots have been visited, go IDLE and drop busy. Otherwise, if the latched mask bit for idx is 1, go ISSUE; else advance idx (1 cycle per skipped client).
- ISSUE: start[idx]=1 for exactly one cycle; timer cleared; go WAIT. Client 0 enabled -> start[0] high in cycle T+2.
- WAIT: done is sampled only for the current idx, from the cycle after ISSUE. Other done bits and done during ISSUE are ignored. Priority, highest first:
  - done[idx]=1 -> advance, SCAN next cycle; the next enabled client's start follows 2 cycles after done.
  - timer==TIMEOUT-1 -> set timeout_flag[idx], advance, SCAN.
  - y==0 && x==0 -> set overrun, go IDLE, busy=0; remaining clients are skipped this frame.
- If done and timeout occur in the same cycle, done wins and no flag is set.
- An event while busy is ignored; frame_tick and frame_count still update.
- clear_flags zeroes timeout_flag and overrun on the next edge. A set event in the same cycle wins.
- All-zero mask: busy is high for N_CLIENTS+1 cycles and no start is issued.
- enable_mask changes mid-pass have no effect until the next pass.

Optional Feature:
- Macro: SCHED_ROUND_ROBIN_EN.
- Defined: the start index rotates by one (mod N_CLIENTS) after each pass that starts, whether it completes or overruns. Visit order wraps idx from N_CLIENTS-1 to 0 until all N_CLIENTS slots have been visited once, so a persistently overrunning pass does not starve the same tail clients.
- Undefined: every pass starts at client 0 and visits in ascending order; no rotation register is built.

Test Plan:
1. Reset release, mask=4'b1111, clients ack 3 cycles after start -> frame_tick at event+1; start[0..3] in order; start[n+1] exactly 2 cycles after done[n]; busy falls after the last SCAN; frame_count=1.
2. Mask=4'b0101 -> only start[0] and start[2] pulse; clients 1 and 3 are each skipped in one SCAN cycle; no start[1] or start[3] ever appears.
3. Client 1 never acks, TIMEOUT=16 -> timeout_flag=4'b0010 16 cycles after start[1]; start[2] follows. Pulse clear_flags -> flag returns to 0. Set and clear in the same cycle -> flag stays 1.
4. Client 2 holds off past y wrap to 0 (large TIMEOUT) -> overrun=1, busy=0 at x==0,y==0; start[3] is never issued; the next frame's pass runs normally.
5. FRAME_DIV=3 over 6 frames -> 6 frame_ticks, passes only on frames 1 and 4; frame_count=6.
6. With SCHED_ROUND_ROBIN_EN, mask=4'b1111, 3 frames -> first start is start[0], then start[1], then start[2]. Without the macro -> start[0] first every frame.
